// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, selects the next fetch address,
// drives the instruction SRAM and hands {pc, inst, adef} to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_adef,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    localparam int unsigned XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic            rst_q,            rst_d;
    logic            fs_valid_q,       fs_valid_d;
    logic [XLEN-1:0] fs_pc_q,          fs_pc_d;
    logic            adef_q,           adef_d;
    logic            buf_valid_q,      buf_valid_d;
    logic [XLEN-1:0] inst_buf_q,       inst_buf_d;
    logic            br_pend_q,        br_pend_d;
    logic [XLEN-1:0] br_pend_target_q, br_pend_target_d;

    logic            to_fs_valid;
    logic            fs_ready_go;
    logic            fs_allowin;
    logic            accept;
    logic            ds_handshake;
    logic [XLEN-1:0] nextpc;

    // Handshake, next-PC selection and next-state for every flop.
    always_comb begin
        to_fs_valid  = ~rst_q;
        fs_ready_go  = 1'b1;
        fs_allowin   = ~fs_valid_q | (fs_ready_go & ds_allowin);
        accept       = to_fs_valid & fs_allowin;
        ds_handshake = fs_valid_q & ~br_taken & ds_allowin;

        if (br_taken) begin
            nextpc = br_target;
        end else if (br_pend_q) begin
            nextpc = br_pend_target_q;
        end else begin
            nextpc = fs_pc_q + PC_STEP;
        end

        rst_d            = 1'b0;
        fs_valid_d       = fs_valid_q;
        fs_pc_d          = fs_pc_q;
        adef_d           = adef_q;
        buf_valid_d      = buf_valid_q;
        inst_buf_d       = inst_buf_q;
        br_pend_d        = br_pend_q;
        br_pend_target_d = br_pend_target_q;

        // A cancel from decode always beats holding the current entry.
        if (accept) begin
            fs_valid_d = 1'b1;
            fs_pc_d    = nextpc;
            adef_d     = (nextpc[1:0] != 2'b00);
        end else if (ds_handshake | br_taken) begin
            fs_valid_d = 1'b0;
        end

        // A redirect that cannot be accepted this cycle is remembered.
        if (br_taken & ~fs_allowin) begin
            br_pend_d        = 1'b1;
            br_pend_target_d = br_target;
        end else if (accept) begin
            br_pend_d = 1'b0;
        end

        // SRAM data lives one cycle; grab it on the first stalled cycle.
        if (ds_handshake | br_taken) begin
            buf_valid_d = 1'b0;
        end else if (fs_valid_q & ~buf_valid_q & ~ds_allowin) begin
            buf_valid_d = 1'b1;
            inst_buf_d  = inst_sram_rdata;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rst_q            <= 1'b1;
            fs_valid_q       <= 1'b0;
            fs_pc_q          <= RESET_PC - PC_STEP;
            adef_q           <= 1'b0;
            buf_valid_q      <= 1'b0;
            inst_buf_q       <= '0;
            br_pend_q        <= 1'b0;
            br_pend_target_q <= '0;
        end else begin
            rst_q            <= rst_d;
            fs_valid_q       <= fs_valid_d;
            fs_pc_q          <= fs_pc_d;
            adef_q           <= adef_d;
            buf_valid_q      <= buf_valid_d;
            inst_buf_q       <= inst_buf_d;
            br_pend_q        <= br_pend_d;
            br_pend_target_q <= br_pend_target_d;
        end
    end

    // Decode-facing and SRAM-facing outputs.
    always_comb begin
        fs_to_ds_valid  = fs_valid_q & ~br_taken;
        fs_pc           = fs_pc_q;
        fs_adef         = adef_q;
        fs_inst         = adef_q ? '0 : (buf_valid_q ? inst_buf_q : inst_sram_rdata);
        inst_sram_en    = accept & (nextpc[1:0] == 2'b00);
        inst_sram_we    = 4'b0000;
        inst_sram_addr  = nextpc;
        inst_sram_wdata = '0;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage for the pipelined LoongArch core. It sits directly upstream of the decode stage and drives the instruction SRAM port.
- Owns the PC and a pre-IF next-PC selector. Applies branch redirects coming back from decode.
- Presents {pc, inst, adef} to decode over a valid/allowin handshake. A one-entry instruction buffer absorbs decode stalls, because the SRAM read data is only valid for one cycle.

Parameters:
RESET_PC, 32'h1c00_0000, address of the first instruction fetched after reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
resetn  input  1  synchronous reset, active low.
ds_allowin  input  1  decode can accept an instruction this cycle.
br_taken  input  1  redirect request from decode; combinational, single-cycle pulse.
br_target  input  32  redirect address; valid when br_taken=1.
fs_to_ds_valid  output  1  fs_pc/fs_inst/fs_adef are valid for decode.
fs_pc  output  32  PC of the presented instruction.
fs_inst  output  32  instruction word.
fs_adef  output  1  fetch-address-misaligned flag for fs_pc.
inst_sram_en  output  1  SRAM read enable.
inst_sram_we  output  4  SRAM byte write enable; tied to 0.
inst_sram_addr  output  32  SRAM address; equals nextpc.
inst_sram_wdata  output  32  tied to 0.
inst_sram_rdata  input  32  SRAM read data; valid the cycle after a request is enabled.

Behaviour:
- Reset (resetn=0 at posedge):
  - fs_valid<=0, fs_pc<=RESET_PC-4, buf_valid<=0, br_pend<=0, rst_q<=1.
  - Consequences: fs_to_ds_valid=0, inst_sram_en=0, fs_adef=0.
- Otherwise rst_q<=0 each cycle.
- Pre-IF:
  - to_fs_valid = ~rst_q. The first request is therefore issued one cycle after resetn rises.
- Handshake:
  - fs_ready_go = 1.
  - fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin).
  - fs_to_ds_valid = fs_valid & ~br_taken. A same-cycle redirect kills the wrong-path instruction.
- Next-PC priority:
  1. br_taken → br_target.
  2. br_pend → br_pend_target.
  3. Otherwise fs_pc+4, with 32-bit wrap and no overflow handling.
- Redirect held over a stall:
  - If br_taken=1 and fs_allowin=0, latch br_pend<=1 and br_pend_target<=br_target.
  - A newer br_taken overwrites a pending redirect.
  - br_pend clears on the cycle the request is accepted (to_fs_valid & fs_allowin).
- Request:
  - inst_sram_en = to_fs_valid & fs_allowin & (nextpc[1:0]==0).
  - inst_sram_addr = nextpc at all times.
- Acceptance (to_fs_valid & fs_allowin):
  - fs_valid<=1, fs_pc<=nextpc, adef_q<=(nextpc[1:0]!=0).
- No acceptance:
  - If fs_to_ds_valid & ds_allowin, or br_taken, then fs_valid<=0.
  - Cancel always wins over hold.
- Instruction buffer:
  - Capture when fs_valid & ~buf_valid & ~ds_allowin & ~br_taken: inst_buf<=inst_sram_rdata, buf_valid<=1.
  - buf_valid<=0 on handshake completion or on br_taken.
  - fs_inst = adef_q ? 32'h0 : (buf_valid ? inst_buf : inst_sram_rdata).
  - The buffer only needs to be captured in the first stalled cycle. While stalled, en=0, so the SRAM output is not relied upon afterwards.
- Outputs: fs_adef = adef_q.
- Misaligned target:
  - No SRAM access is made.
  - The instruction is still delivered, with fs_adef=1 and fs_inst=0.
  - Fetch then continues sequentially from that pc+4.
- Steady-state throughput: one instruction per cycle with no stall.
- Reset mid-operation:
  - Any in-flight instruction, buffer contents and pending branch are dropped.
  - Fetch restarts at RESET_PC.

Test Plan:
1. Reset → resetn 0 for 3 cycles, then 1 → cycle +1 after release: en=0. Cycle +2: en=1, addr=1c000000. Cycle +3: fs_to_ds_valid=1, fs_pc=1c000000, fs_inst=rdata.
2. Sequential fetch → ds_allowin=1, SRAM returns pc-derived data → back-to-back fs_pc 1c000000, 1c000004, 1c000008 on consecutive cycles, one per cycle.
3. Decode stall → ds_allowin=0 for 4 cycles at fs_pc=1c000008, SRAM output randomized after the first cycle → fs_inst holds the first-cycle word. en=0 during the stall. Release → next pc is 1c00000c.
4. Unstalled branch → br_taken=1, br_target=1c000100 while fs_pc=1c000008 → fs_to_ds_valid=0 that cycle, addr=1c000100 that cycle, fs_pc=1c000100 next cycle.
5. Branch during stall → ds_allowin=0, br_taken pulse to 1c000200, then ds_allowin=1 two cycles later → no stale instruction delivered; next fs_pc=1c000200.
6. Misaligned target and mid-run reset → br_target=1c000102 gives en=0, fs_adef=1, fs_inst=0, then fs_pc=1c000106. Asserting resetn=0 mid-stream gives fs_to_ds_valid=0 next cycle, and the restart resumes at 1c000000.
